// File: rtl/hs_arbiter.sv
// hs_arbiter: shares one hs slave port between two hs masters.
// M0 is the AXI bridge hs side, M1 is the debug/DMA requester.
// Round-robin, registered grant; one transaction in flight at a time.
// Optional feature macro: HS_ARB_TIMEOUT_EN. When defined, a busy counter
// forces a one-cycle ABORT after TIMEOUT_CYCLES cycles without s_ready_i.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no grant; arbitrate between pending requests
// BUSY  | slave port muxed to the granted master, waiting for s_ready_i
// ABORT | (HS_ARB_TIMEOUT_EN only) fake completion with 0xDEADBEEF
module hs_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [1:0]          m_read_i,
   input  logic [1:0]          m_write_i,
   input  logic [2*ADDR_W-1:0] m_addr_i,
   input  logic [2*DATA_W-1:0] m_wdata_i,
   input  logic [7:0]          m_byte_select_i,
   output logic [1:0]          m_ready_o,
   output logic [DATA_W-1:0]   m_rdata_o,
   output logic                s_read_o,
   output logic                s_write_o,
   output logic [ADDR_W-1:0]   s_addr_o,
   output logic [DATA_W-1:0]   s_wdata_o,
   output logic [3:0]          s_byte_select_o,
   input  logic                s_ready_i,
   input  logic [DATA_W-1:0]   s_rdata_i,
   output logic [1:0]          grant_o,
   output logic                timeout_o
);

`ifdef HS_ARB_TIMEOUT_EN
   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ABORT} state_t;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_BUSY} state_t;
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

   state_t     state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic       rr_q, rr_d;
   logic [1:0] req;
   logic       g_idx;

   assign req     = m_read_i | m_write_i;
   // grant is one-hot, so bit 1 alone identifies the owner
   assign g_idx   = grant_q[1];
   assign grant_o = grant_q;

   // state, grant and round-robin pointer registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         grant_q <= 2'b00;
         rr_q    <= 1'b0;
`ifdef HS_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
`ifdef HS_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // next-state: arbitration in IDLE, completion/withdrawal/timeout in BUSY
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
`ifdef HS_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               state_d = ST_BUSY;
               if (req == 2'b11) grant_d = rr_q ? 2'b10 : 2'b01;
               else              grant_d = req;
`ifdef HS_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         ST_BUSY: begin
            if (s_ready_i) begin
               state_d = ST_IDLE;
               grant_d = 2'b00;
               rr_d    = ~g_idx;
            end else if (!req[g_idx]) begin
               // withdrawn request: drop the grant without touching rr
               state_d = ST_IDLE;
               grant_d = 2'b00;
            end
`ifdef HS_ARB_TIMEOUT_EN
            else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) state_d = ST_ABORT;
            end
`endif
         end
`ifdef HS_ARB_TIMEOUT_EN
         ST_ABORT: begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
            rr_d    = ~g_idx;
         end
`endif
         default: begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   // output mux: slave side from the granted slice, response back to owner only
   always_comb begin
      s_read_o        = 1'b0;
      s_write_o       = 1'b0;
      s_addr_o        = '0;
      s_wdata_o       = '0;
      s_byte_select_o = 4'h0;
      m_ready_o       = 2'b00;
      m_rdata_o       = '0;
      timeout_o       = 1'b0;
      if (state_q == ST_BUSY) begin
         s_read_o        = m_read_i[g_idx];
         s_write_o       = m_write_i[g_idx] & ~m_read_i[g_idx];
         s_addr_o        = g_idx ? m_addr_i[2*ADDR_W-1:ADDR_W] : m_addr_i[ADDR_W-1:0];
         s_wdata_o       = g_idx ? m_wdata_i[2*DATA_W-1:DATA_W] : m_wdata_i[DATA_W-1:0];
         s_byte_select_o = g_idx ? m_byte_select_i[7:4] : m_byte_select_i[3:0];
         m_ready_o[g_idx] = s_ready_i;
         m_rdata_o       = s_rdata_i;
      end
`ifdef HS_ARB_TIMEOUT_EN
      else if (state_q == ST_ABORT) begin
         m_ready_o[g_idx] = 1'b1;
         m_rdata_o        = DATA_W'(32'hDEAD_BEEF);
         timeout_o        = 1'b1;
      end
`endif
   end

endmodule

// File: tb/tb_hs_arbiter.sv
// Bench for hs_arbiter: directed scenarios followed by random masters and a
// random slave, all checked every cycle against a transaction-level model.
module tb_hs_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    m_read, m_write;
   logic [63:0]   m_addr, m_wdata;
   logic [7:0]    m_be;
   logic [1:0]    m_ready_o;
   logic [31:0]   m_rdata_o;
   logic          s_read_o, s_write_o;
   logic [31:0]   s_addr_o, s_wdata_o;
   logic [3:0]    s_byte_select_o;
   logic          s_ready;
   logic [31:0]   s_rdata;
   logic [1:0]    grant_o;
   logic          timeout_o;

   int tests = 0;
   int fails = 0;

   // reference model: who owns the slave, whose turn it is on a tie
   int         owner = -1;
   int         pref = 0;
   int         busy_n = 0;
   bit         aborting = 1'b0;
   logic [1:0] exp_ready = 2'b00;

   always #5 clk = ~clk;

   hs_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .rst_i(rst),
      .m_read_i(m_read), .m_write_i(m_write), .m_addr_i(m_addr),
      .m_wdata_i(m_wdata), .m_byte_select_i(m_be),
      .m_ready_o(m_ready_o), .m_rdata_o(m_rdata_o),
      .s_read_o(s_read_o), .s_write_o(s_write_o), .s_addr_o(s_addr_o),
      .s_wdata_o(s_wdata_o), .s_byte_select_o(s_byte_select_o),
      .s_ready_i(s_ready), .s_rdata_i(s_rdata),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );

   task automatic chk_all(input string tag, input logic [106:0] obs, input logic [106:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // compare all outputs with the model, then advance the model one cycle
   task automatic model_step(input string tag);
      logic [1:0]  e_grant, e_ready, req;
      logic [31:0] e_rdata, e_addr, e_wdata;
      logic [3:0]  e_be;
      logic        e_sr, e_sw, e_to;
      e_grant = 2'b00; e_ready = 2'b00; e_rdata = '0; e_addr = '0; e_wdata = '0;
      e_be = 4'h0; e_sr = 1'b0; e_sw = 1'b0; e_to = 1'b0;
      req = m_read | m_write;
      if (owner >= 0) e_grant = (owner == 1) ? 2'b10 : 2'b01;
      if (aborting) begin
         e_ready = e_grant;
         e_rdata = 32'hDEAD_BEEF;
         e_to    = 1'b1;
      end else if (owner >= 0) begin
         e_sr    = m_read[owner];
         e_sw    = m_write[owner] & ~m_read[owner];
         e_addr  = m_addr[owner*32 +: 32];
         e_wdata = m_wdata[owner*32 +: 32];
         e_be    = m_be[owner*4 +: 4];
         e_ready = s_ready ? e_grant : 2'b00;
         e_rdata = s_rdata;
      end
      chk_all(tag,
         {grant_o, m_ready_o, m_rdata_o, s_read_o, s_write_o, s_addr_o, s_wdata_o, s_byte_select_o, timeout_o},
         {e_grant, e_ready, e_rdata, e_sr, e_sw, e_addr, e_wdata, e_be, e_to});
      exp_ready = e_ready;
      if (rst) begin
         owner = -1; pref = 0; aborting = 1'b0;
      end else if (aborting) begin
         pref = 1 - owner; owner = -1; aborting = 1'b0;
      end else if (owner < 0) begin
         if (req != 2'b00) begin
            owner  = (req == 2'b11) ? pref : (req[1] ? 1 : 0);
            busy_n = 0;
         end
      end else if (s_ready) begin
         pref = 1 - owner; owner = -1;
      end else if (!req[owner]) begin
         owner = -1;
      end
`ifdef HS_ARB_TIMEOUT_EN
      else begin
         busy_n++;
         if (busy_n == TO) aborting = 1'b1;
      end
`endif
   endtask

   task automatic cycle(input string tag);
      @(negedge clk);
      model_step(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m_read = 2'b00; m_write = 2'b00; m_addr = '0; m_wdata = '0; m_be = '0;
      s_ready = 1'b0; s_rdata = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      owner = -1; pref = 0; aborting = 1'b0; exp_ready = 2'b00;
   endtask

   task automatic new_req(input int n);
      int kind;
      kind = int'($urandom_range(0, 3));
      m_read[n]  = (kind <= 1) || (kind == 3);
      m_write[n] = (kind >= 2);
      m_addr[n*32 +: 32]  = $urandom;
      m_wdata[n*32 +: 32] = $urandom;
      m_be[n*4 +: 4]      = 4'($urandom);
   endtask

   // protocol-following random masters plus a random-latency slave
   task automatic agents();
      for (int n = 0; n < 2; n++) begin
         if (exp_ready[n] || !(m_read[n] | m_write[n])) begin
            if ($urandom_range(0, 1) == 1) new_req(n);
            else begin m_read[n] = 1'b0; m_write[n] = 1'b0; end
         end else if ($urandom_range(0, 49) == 0) begin
            m_read[n] = 1'b0; m_write[n] = 1'b0;
         end
      end
      s_ready = ($urandom_range(0, 2) == 0);
      s_rdata = $urandom;
      rst     = ($urandom_range(0, 99) == 0);
   endtask

   initial begin
      logic [1:0] seq [7];
      seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
      clear_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      chk32("rst_grant", 32'(grant_o), 32'h0);
      chk32("rst_ready", 32'(m_ready_o), 32'h0);
      chk32("rst_sreq", 32'({s_read_o, s_write_o}), 32'h0);

      // 1: M0 read with three wait cycles
      m_read[0] = 1'b1; m_addr[31:0] = 32'h100;
      cycle("t1");
      chk32("t1_grant", 32'(grant_o), 32'h1);
      chk32("t1_sread", 32'(s_read_o), 32'h1);
      chk32("t1_addr", s_addr_o, 32'h100);
      repeat (3) cycle("t1");
      s_ready = 1'b1; s_rdata = 32'h1234_5678;
      #1;
      chk32("t1_ready", 32'(m_ready_o), 32'h1);
      chk32("t1_rdata", m_rdata_o, 32'h1234_5678);
      cycle("t1");
      m_read[0] = 1'b0; s_ready = 1'b0;
      #1;
      chk32("t1_sread_after", 32'(s_read_o), 32'h0);
      cycle("t1");

      // 2: simultaneous requests after reset, M0 first
      do_reset();
      m_write[0] = 1'b1; m_addr[31:0] = 32'h40; m_wdata[31:0] = 32'hCAFE_F00D; m_be[3:0] = 4'hF;
      m_read[1] = 1'b1; m_addr[63:32] = 32'h80;
      cycle("t2");
      chk32("t2_grant0", 32'(grant_o), 32'h1);
      chk32("t2_swrite", 32'(s_write_o), 32'h1);
      chk32("t2_wdata", s_wdata_o, 32'hCAFE_F00D);
      s_ready = 1'b1;
      cycle("t2");
      m_write[0] = 1'b0; s_ready = 1'b0;
      #1;
      chk32("t2_idle", 32'({grant_o, s_read_o, s_write_o}), 32'h0);
      cycle("t2");
      chk32("t2_grant1", 32'(grant_o), 32'h2);
      chk32("t2_sread", 32'(s_read_o), 32'h1);
      chk32("t2_addr", s_addr_o, 32'h80);
      s_ready = 1'b1;
      cycle("t2");
      m_read[1] = 1'b0; s_ready = 1'b0;
      cycle("t2");

      // 3: both masters continuously, zero-wait slave
      do_reset();
      m_read = 2'b11; s_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         cycle("t3");
         chk32("t3_grant", 32'(grant_o), 32'(seq[i]));
         chk32("t3_ready", 32'(m_ready_o), 32'(seq[i]));
      end
      clear_inputs();
      cycle("t3");

      // 4: M1 read and write together, read wins
      do_reset();
      m_read[1] = 1'b1; m_write[1] = 1'b1; m_addr[63:32] = 32'h10;
      cycle("t4");
      chk32("t4_rw", 32'({s_read_o, s_write_o}), 32'h2);
      s_ready = 1'b1;
      #1;
      chk32("t4_ready", 32'(m_ready_o), 32'h2);
      cycle("t4");
      clear_inputs();
      cycle("t4");

      // 5: reset during BUSY, with rr pointing at M1 beforehand
      do_reset();
      m_read[0] = 1'b1;
      cycle("t5");
      s_ready = 1'b1;
      cycle("t5");
      m_read = 2'b10; s_ready = 1'b0;
      cycle("t5");
      chk32("t5_grant1", 32'(grant_o), 32'h2);
      cycle("t5");
      rst = 1'b1;
      cycle("t5");
      rst = 1'b0;
      #1;
      chk32("t5_after_rst", 32'({grant_o, m_ready_o, s_read_o, s_write_o}), 32'h0);
      m_read = 2'b11;
      cycle("t5");
      chk32("t5_grant0", 32'(grant_o), 32'h1);
      clear_inputs();
      cycle("t5");
      cycle("t5");

`ifdef HS_ARB_TIMEOUT_EN
      // 6: unresponsive slave forces an abort
      do_reset();
      m_read[0] = 1'b1; m_addr[31:0] = 32'h200;
      cycle("t6");
      repeat (TO) cycle("t6");
      chk32("t6_ready", 32'(m_ready_o), 32'h1);
      chk32("t6_rdata", m_rdata_o, 32'hDEAD_BEEF);
      chk32("t6_timeout", 32'(timeout_o), 32'h1);
      chk32("t6_sread", 32'(s_read_o), 32'h0);
      m_read[0] = 1'b0;
      cycle("t6");
      s_ready = 1'b1;
      #1;
      chk32("t6_late", 32'(m_ready_o), 32'h0);
      cycle("t6");
      s_ready = 1'b0;
`endif

      // random masters and slave against the model
      do_reset();
      repeat (3000) begin
         agents();
         cycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
